// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial "1011" detector.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         PAT_LEN = 4;

endpackage

// File: rtl/seq_detector_1011_if.sv
// Serial stream in, detect flag out; match_count exists only with SEQ_DET_COUNT_EN.
interface seq_detector_1011_if #(
  parameter int CNT_W = 8
);
  logic sequence_in;
  logic detector_out;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] match_count;

  modport master (output sequence_in, input detector_out, input match_count);
  modport slave  (input sequence_in, output detector_out, output match_count);
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be >= 1");
  end

  modport master (output sequence_in, input detector_out);
  modport slave  (input sequence_in, output detector_out);
`endif
endinterface

// File: rtl/seq_det_counter.sv
// Wrapping up-counter with synchronous active-low clear and increment enable.
module seq_det_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_detector_1011.sv
// Moore FSM detecting serial "1011", MSB first. Optional match counter under
// SEQ_DET_COUNT_EN.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  seq_detector_1011_if.slave  bus
);
  state_e state_q, state_d;

  if (CNT_W < 1 || PAT_LEN != $bits(PATTERN)) begin : g_bad_cfg
    $error("seq_detector_1011: bad configuration");
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.sequence_in ? S1    : IDLE;
      S1:      state_d = bus.sequence_in ? S1    : S10;
      S10:     state_d = bus.sequence_in ? S101  : IDLE;
      S101:    state_d = bus.sequence_in ? S1011 : S10;
      // the trailing '1' keeps us in S1 either way; only a '0' differs
      S1011:   state_d = bus.sequence_in ? S1 : (OVERLAP ? S10 : IDLE);
      default: state_d = IDLE;
    endcase
  end

  assign bus.detector_out = (state_q == S1011);

`ifdef SEQ_DET_COUNT_EN
  seq_det_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (state_d == S1011),
    .cnt_o (bus.match_count)
  );
`endif
endmodule

// File: tb/tb_seq_detector_1011.sv
// Scoreboard bench: overlapping and non-overlapping detectors share one stream;
// hand-computed per-bit expectations are queued and checked by a monitor.
module tb_seq_detector_1011;
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  seq_detector_1011_if #(.CNT_W(2)) bus1 ();
  seq_detector_1011_if #(.CNT_W(2)) bus0 ();

  seq_detector_1011 #(.OVERLAP(1'b1), .CNT_W(2)) dut_ovl (
    .clock (clock), .reset (reset), .bus (bus1.slave));
  seq_detector_1011 #(.OVERLAP(1'b0), .CNT_W(2)) dut_non (
    .clock (clock), .reset (reset), .bus (bus0.slave));

  int n_chk  = 0;
  int n_fail = 0;

  logic       q1 [$];
  logic       q0 [$];
  logic [1:0] qc1 [$];
  logic [1:0] qc0 [$];
  logic [1:0] c1 = 2'd0;
  logic [1:0] c0 = 2'd0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One bit per cycle; x1/x0 are the expected flags after the edge for each build.
  task automatic drive(input logic b, input logic r, input logic x1, input logic x0);
    @(negedge clock);
    reset = r;
    bus1.sequence_in = b;
    bus0.sequence_in = b;
    if (!r) begin
      c1 = 2'd0;
      c0 = 2'd0;
    end else begin
      c1 = c1 + 2'(x1);
      c0 = c0 + 2'(x0);
    end
    q1.push_back(x1);
    q0.push_back(x0);
    qc1.push_back(c1);
    qc0.push_back(c0);
  endtask

  task automatic run(input string bits, input string x1, input string x0);
    for (int i = 0; i < bits.len(); i++)
      drive(bits[i] == "1", 1'b1, x1[i] == "1", x0[i] == "1");
  endtask

  task automatic rst_cycles(input int n, input logic b);
    for (int i = 0; i < n; i++) drive(b, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the flag is a per-cycle output, so one entry is consumed per edge.
  always begin
    logic e1, e0;
    logic [1:0] ec1, ec0;
    @(posedge clock);
    #1;
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      ec1 = qc1.pop_front();
      ec0 = qc0.pop_front();
      check("det_overlap", {1'b0, bus1.detector_out}, {1'b0, e1});
      check("det_nonovl",  {1'b0, bus0.detector_out}, {1'b0, e0});
`ifdef SEQ_DET_COUNT_EN
      check("cnt_overlap", bus1.match_count, ec1);
      check("cnt_nonovl",  bus0.match_count, ec0);
`else
      if (ec1 === 2'bxx || ec0 === 2'bxx) $display("note: count model undefined");
`endif
    end
  end

  initial begin
    bus1.sequence_in = 1'b0;
    bus0.sequence_in = 1'b0;

    // reset held for 3 edges with random data
    for (int i = 0; i < 3; i++) rst_cycles(1, 1'($urandom_range(0, 1)));

    // overlap stream
    run("00001010110110", "00000000010010", "00000000010000");
    rst_cycles(1, 1'b0);

    // overlap vs non-overlap
    run("1011011", "0001001", "0001000");
    rst_cycles(1, 1'b0);

    // near misses
    run("1111", "0000", "0000");
    rst_cycles(1, 1'b0);
    run("10011", "00000", "00000");
    rst_cycles(1, 1'b0);
    run("101010", "000000", "000000");
    rst_cycles(1, 1'b0);

    // mid-pattern reset: the '1' sampled at the reset edge is ignored
    run("101", "000", "000");
    rst_cycles(1, 1'b1);
    run("1", "0", "0");
    run("1011", "0001", "0001");
    rst_cycles(1, 1'b0);

    // five back-to-back overlapping matches; 2-bit counter wraps 1,2,3,0,1
    run("1011011011011011", "0001001001001001", "0001000001000001");
    rst_cycles(1, 1'b0);

    begin
      int waited = 0;
      while (q1.size() != 0 && waited < 10) begin
        @(posedge clock);
        waited++;
      end
      @(negedge clock);
      n_chk++;
      if (q1.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", q1.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
